// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment data is active-low {g,f,e,d,c,b,a}.
package ssd_pkg;

  typedef enum logic [1:0] {
    DIG_1 = 2'd0,
    DIG_2 = 2'd1,
    DIG_3 = 2'd2,
    DIG_4 = 2'd3
  } digit_e;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] ANODE_OFF = 4'hF;

  // Index 0 is the rightmost element of the concatenation.
  localparam logic [15:0][6:0] GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // val[3] is digit 1, matching the bit order of i_Dp and o_Anode.
  typedef struct packed {
    logic [3:0][3:0] val;
    logic [3:0]      dp;
  } snap_t;

  function automatic logic [1:0] digit_pos(digit_e d);
    return 2'd3 - d;
  endfunction

  function automatic logic [3:0] anode_sel(digit_e d);
    return ~(4'b1000 >> d);
  endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Hex value to active-low seven-segment glyph, with a force-blank input.
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  output logic [6:0] cathode
);

  assign cathode = blank ? SEG_BLANK : GLYPHS[value];

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit multiplexed seven-segment driver: per-slot dead time, per-scan
// input snapshot, optional leading-zero blanking, all outputs registered.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int c_REFRESH_DIV  = 100000,
  parameter int c_BLANK_CYCLES = 16,
  parameter int c_LZ_BLANK     = 0
) (
  input  logic       i_CLK,
  input  logic       i_RST_N,
  input  logic       i_Enable,
  input  logic [3:0] i_Digit_1_val,
  input  logic [3:0] i_Digit_2_val,
  input  logic [3:0] i_Digit_3_val,
  input  logic [3:0] i_Digit_4_val,
  input  logic [3:0] i_Dp,
  output logic [3:0] o_Anode,
  output logic [6:0] o_Cathode,
  output logic       o_Dp
);

  localparam int              CW        = $clog2(c_REFRESH_DIV);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(c_REFRESH_DIV - 1);
  localparam logic [CW-1:0]   CNT_BLANK = CW'(c_BLANK_CYCLES);

  state_e        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  digit_e        idx, idx_nx;
  snap_t         snap, snap_nx;
  logic [3:0]    anode_nx;
  logic [6:0]    cathode_nx;
  logic          dp_nx;
  logic          first_cycle;
  logic [1:0]    pos;
  logic          lz_blank;

  // OFF always leaves cnt=0 and idx=DIG_1, so it is also a slot-1 start.
  assign first_cycle = (state == ST_OFF) || (cnt == '0 && idx == DIG_1);

  always_comb begin
    cnt_nx   = cnt;
    idx_nx   = idx;
    snap_nx  = snap;
    state_nx = ST_OFF;
    if (!i_Enable) begin
      cnt_nx = '0;
      idx_nx = DIG_1;
    end else begin
      if (first_cycle) begin
        snap_nx.val = {i_Digit_1_val, i_Digit_2_val, i_Digit_3_val, i_Digit_4_val};
        snap_nx.dp  = i_Dp;
      end
      if (cnt == CNT_LAST) begin
        cnt_nx = '0;
        idx_nx = digit_e'(idx + 2'd1);
      end else begin
        cnt_nx = cnt + CW'(1);
      end
      state_nx = (cnt_nx < CNT_BLANK) ? ST_BLANK : ST_SHOW;
    end
  end

  // Outputs are computed from next-state values so they line up with cnt.
  assign pos = digit_pos(idx_nx);

  always_comb begin
    lz_blank = 1'b0;
    if (c_LZ_BLANK != 0) begin
      case (idx_nx)
        DIG_1:   lz_blank = (snap_nx.val[3]   == '0);
        DIG_2:   lz_blank = (snap_nx.val[3:2] == '0);
        DIG_3:   lz_blank = (snap_nx.val[3:1] == '0);
        default: lz_blank = 1'b0;
      endcase
    end
  end

  always_comb begin
    anode_nx = ANODE_OFF;
    dp_nx    = 1'b1;
    if (state_nx == ST_SHOW) begin
      anode_nx = anode_sel(idx_nx);
      dp_nx    = ~snap_nx.dp[pos];
    end
  end

  ssd_hex_decoder u_dec (
    .value   (snap_nx.val[pos]),
    .blank   (lz_blank || (state_nx != ST_SHOW)),
    .cathode (cathode_nx)
  );

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state     <= ST_OFF;
      cnt       <= '0;
      idx       <= DIG_1;
      snap      <= '0;
      o_Anode   <= ANODE_OFF;
      o_Cathode <= SEG_BLANK;
      o_Dp      <= 1'b1;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      idx       <= idx_nx;
      snap      <= snap_nx;
      o_Anode   <= anode_nx;
      o_Cathode <= cathode_nx;
      o_Dp      <= dp_nx;
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scan driver bench: plain and leading-zero-blanking instances share stimulus
// and are compared every cycle against a time-based model of the display.
module tb_ssd_scan_driver;

  localparam int DIV  = 8;
  localparam int BLK  = 2;
  localparam int SCAN = 4 * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [3:0] d1 = '0, d2 = '0, d3 = '0, d4 = '0, dp = '0;
  logic [3:0] an0, an1;
  logic [6:0] ca0, ca1;
  logic       dp0, dp1;

  always #5 clk = ~clk;

  ssd_scan_driver #(.c_REFRESH_DIV(DIV), .c_BLANK_CYCLES(BLK), .c_LZ_BLANK(0)) u_plain (
    .i_CLK(clk), .i_RST_N(rst_n), .i_Enable(en),
    .i_Digit_1_val(d1), .i_Digit_2_val(d2), .i_Digit_3_val(d3), .i_Digit_4_val(d4),
    .i_Dp(dp), .o_Anode(an0), .o_Cathode(ca0), .o_Dp(dp0)
  );

  ssd_scan_driver #(.c_REFRESH_DIV(DIV), .c_BLANK_CYCLES(BLK), .c_LZ_BLANK(1)) u_lz (
    .i_CLK(clk), .i_RST_N(rst_n), .i_Enable(en),
    .i_Digit_1_val(d1), .i_Digit_2_val(d2), .i_Digit_3_val(d3), .i_Digit_4_val(d4),
    .i_Dp(dp), .o_Anode(an1), .o_Cathode(ca1), .o_Dp(dp1)
  );

  int checks = 0;
  int errors = 0;

  // Model: t = cycles since the current scan sequence started.
  int         t = 0;
  bit         off = 1'b1;
  logic [3:0] sv [4];
  logic [3:0] sdp = '0;
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed %h expected %h", tag, t, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int slot, pos;
    bit show, lz;
    logic [3:0] ea;
    logic [6:0] ec, ecl;
    logic edp;
    slot = (t / DIV) % 4;
    pos  = t % DIV;
    show = !off && rst_n && (pos >= BLK);
    ea   = show ? ~(4'b1000 >> slot) : 4'hF;
    ec   = show ? glyph[sv[slot]] : 7'h7F;
    lz   = (slot != 3);
    for (int k = 0; k <= slot; k++) if (sv[k] != 4'd0) lz = 1'b0;
    ecl  = (show && !lz) ? glyph[sv[slot]] : 7'h7F;
    edp  = show ? ~sdp[3 - slot] : 1'b1;
    check({tag, ".anode"},      {3'b0, an0}, {3'b0, ea});
    check({tag, ".cathode"},    ca0,         ec);
    check({tag, ".dp"},         {6'b0, dp0}, {6'b0, edp});
    check({tag, ".lz_anode"},   {3'b0, an1}, {3'b0, ea});
    check({tag, ".lz_cathode"}, ca1,         ecl);
    check({tag, ".lz_dp"},      {6'b0, dp1}, {6'b0, edp});
  endtask

  task automatic model_reset();
    t = 0; off = 1'b1; sdp = '0;
    for (int k = 0; k < 4; k++) sv[k] = '0;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (rst_n) begin
      if (en) begin
        if (t % SCAN == 0) begin
          sv[0] = d1; sv[1] = d2; sv[2] = d3; sv[3] = d4; sdp = dp;
        end
        t++;
        off = 1'b0;
      end else begin
        t = 0;
        off = 1'b1;
      end
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic wait_show(input string tag, input int slot);
    bit hit = 1'b0;
    for (int i = 0; i < 2 * SCAN && !hit; i++) begin
      if (!off && (t / DIV) % 4 == slot && (t % DIV) >= BLK + 1) hit = 1'b1;
      else step(tag);
    end
    checks++;
    if (!hit) begin
      errors++;
      $error("FAIL %s_wait observed no-show expected show slot %0d", tag, slot);
    end
  endtask

  initial begin
    model_reset();
    d1 = 4'd1; d2 = 4'd2; d3 = 4'd3; d4 = 4'd4; dp = 4'b0000; en = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_all("reset_hold");
    run("reset_hold", 3);
    rst_n = 1'b1;
    run("scan", 64);

    // digit 4 changes during the digit-2 slot; visible only next scan
    run("snap", 10);
    d4 = 4'd9;
    run("snap", 60);

    d1 = 4'd0; d2 = 4'd0; d3 = 4'd0; d4 = 4'd7; dp = 4'b1000;
    run("lz_0007", 64);
    d1 = 4'd0; d2 = 4'd5; d3 = 4'd0; d4 = 4'd0; dp = 4'b0000;
    run("lz_0500", 64);

    wait_show("en_drop", 2);
    en = 1'b0;
    run("en_off", 5);
    d1 = 4'hA; d2 = 4'hB; d3 = 4'hC; d4 = 4'hD; dp = 4'b0101;
    en = 1'b1;
    run("en_back", 40);

    wait_show("async_rst", 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("async_rst");
    run("async_rst", 2);
    rst_n = 1'b1;
    run("after_rst", 40);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 5) begin
        case ($urandom_range(0, 4))
          0: d1 = 4'($urandom);
          1: d2 = 4'($urandom);
          2: d3 = 4'($urandom);
          3: d4 = 4'($urandom);
          default: dp = 4'($urandom);
        endcase
      end
      if ($urandom_range(0, 99) < 4) d1 = 4'd0;
      if ($urandom_range(0, 199) == 0) en = ~en;
      if ($urandom_range(0, 599) == 0) begin
        #3 rst_n = 1'b0;
        model_reset();
        #1 check_all("rand_rst");
        run("rand_rst", 1);
        rst_n = 1'b1;
      end
      if (!en && $urandom_range(0, 19) == 0) en = 1'b1;
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
